// File: rtl/phase_meter_avg.sv
// phase_meter_avg: measures the I/V phase once per drive period framed by the
// cycle reference. Reports |theta|, the period length and the lead/lag direction,
// plus a signed average over 2^AVG_LOG2 valid cycles for the frequency loop.
module phase_meter_avg #(
    parameter int unsigned CNT_W       = 8,
    parameter int unsigned AVG_LOG2    = 2,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic             clk5MHz,
    input  logic             reset,
    input  logic             I,
    input  logic             V,
    input  logic             cycle,
    output logic [CNT_W-1:0] abs_theta,
    output logic [CNT_W-1:0] period,
    output logic             lead,
    output logic             theta_valid,
    output logic [CNT_W:0]   theta_avg,
    output logic             avg_valid,
    output logic             stall
);

    localparam int unsigned      ACC_W  = CNT_W + 1 + AVG_LOG2;
    localparam logic [CNT_W-1:0] CntMax = '1;
    localparam logic [AVG_LOG2:0] GrpLen = (AVG_LOG2 + 1)'(1 << AVG_LOG2);

    typedef enum logic {StIdle, StRun} state_e;

    state_e state_q, state_d;

    logic [SYNC_STAGES-1:0] i_sync_q, v_sync_q, c_sync_q;
    logic                   i_d_q, v_d_q, cyc_d_q;
    logic                   i_s, v_s, cyc_s;
    logic                   pulse, i_rise, v_rise;

    logic [CNT_W-1:0] ph_acc_q, ph_sum;
    logic [CNT_W-1:0] per_cnt_q, per_sum;
    logic             sat_hit;

    logic dir_q, dir_d;

    logic             close_ok, stall_set;
    logic [CNT_W-1:0] abs_q, abs_d, per_q, per_d;
    logic             lead_q, lead_d, tv_q, tv_d, stall_q, stall_d;

    logic signed [ACC_W-1:0] acc_q, acc_d, s_mag, s_val;
    logic [AVG_LOG2:0]       grp_q, grp_d;
    logic [CNT_W:0]          avg_q, avg_d;
    logic                    av_q, av_d;

    assign i_s    = i_sync_q[SYNC_STAGES-1];
    assign v_s    = v_sync_q[SYNC_STAGES-1];
    assign cyc_s  = c_sync_q[SYNC_STAGES-1];
    assign pulse  = cyc_s & ~cyc_d_q;
    assign i_rise = i_s & ~i_d_q;
    assign v_rise = v_s & ~v_d_q;

    // Synchronisers plus one delay flop per signal for edge detection.
    always_ff @(posedge clk5MHz) begin
        if (reset) begin
            i_sync_q <= '0;
            v_sync_q <= '0;
            c_sync_q <= '0;
            i_d_q    <= 1'b0;
            v_d_q    <= 1'b0;
            cyc_d_q  <= 1'b0;
        end else begin
            i_sync_q <= {i_sync_q[SYNC_STAGES-2:0], I};
            v_sync_q <= {v_sync_q[SYNC_STAGES-2:0], V};
            c_sync_q <= {c_sync_q[SYNC_STAGES-2:0], cycle};
            i_d_q    <= i_s;
            v_d_q    <= v_s;
            cyc_d_q  <= cyc_s;
        end
    end

    // Saturating phase and period sums; the pulse-clock sample closes the cycle.
    always_comb begin
        ph_sum  = (ph_acc_q == CntMax) ? CntMax : ph_acc_q + CNT_W'(i_s ^ v_s);
        per_sum = (per_cnt_q == CntMax) ? CntMax : per_cnt_q + CNT_W'(1);
        sat_hit = (per_cnt_q == CntMax);
    end

    // Phase accumulator and period counter both restart on every pulse.
    always_ff @(posedge clk5MHz) begin
        if (reset) begin
            ph_acc_q  <= '0;
            per_cnt_q <= '0;
        end else begin
            ph_acc_q  <= pulse ? '0 : ph_sum;
            per_cnt_q <= pulse ? '0 : per_sum;
        end
    end

    // Direction: the latest unambiguous rising edge decides; simultaneous rises keep it.
    always_comb begin
        dir_d = dir_q;
        if (i_rise && !v_s) begin
            dir_d = 1'b1;
        end else if (v_rise && !i_s) begin
            dir_d = 1'b0;
        end
    end

    // Direction register.
    always_ff @(posedge clk5MHz) begin
        if (reset) begin
            dir_q <= 1'b0;
        end else begin
            dir_q <= dir_d;
        end
    end

    // FSM state register.
    always_ff @(posedge clk5MHz) begin
        if (reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state: a pulse arms from idle, a saturated period drops back to idle.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: if (pulse) state_d = StRun;
            StRun:  if (sat_hit) state_d = StIdle;
        endcase
    end

    // FSM outputs: a cycle closes only in run and only if the period did not saturate.
    always_comb begin
        close_ok  = 1'b0;
        stall_set = 1'b0;
        unique case (state_q)
            StIdle: begin end
            StRun: begin
                stall_set = sat_hit;
                close_ok  = pulse & ~sat_hit;
            end
        endcase
    end

    // Per-cycle result registers hold until the next closed cycle.
    always_comb begin
        abs_d   = close_ok ? ph_sum : abs_q;
        per_d   = close_ok ? per_sum : per_q;
        lead_d  = close_ok ? dir_q : lead_q;
        tv_d    = close_ok;
        stall_d = stall_q;
        if (stall_set) begin
            stall_d = 1'b1;
        end else if (close_ok) begin
            stall_d = 1'b0;
        end
    end

    // Per-cycle result flops.
    always_ff @(posedge clk5MHz) begin
        if (reset) begin
            abs_q   <= '0;
            per_q   <= '0;
            lead_q  <= 1'b0;
            tv_q    <= 1'b0;
            stall_q <= 1'b0;
        end else begin
            abs_q   <= abs_d;
            per_q   <= per_d;
            lead_q  <= lead_d;
            tv_q    <= tv_d;
            stall_q <= stall_d;
        end
    end

    // Signed average: accumulate on close, publish the clock after the group's last strobe.
    always_comb begin
        s_mag = {{(AVG_LOG2 + 1){1'b0}}, ph_sum};
        s_val = dir_q ? -s_mag : s_mag;
        acc_d = acc_q;
        grp_d = grp_q;
        avg_d = avg_q;
        av_d  = 1'b0;
        if (stall_set) begin
            acc_d = '0;
            grp_d = '0;
        end else if (close_ok) begin
            acc_d = acc_q + s_val;
            grp_d = grp_q + (AVG_LOG2 + 1)'(1);
        end else if (tv_q && (grp_q == GrpLen)) begin
            // Upper bits of the accumulator are the arithmetic shift, rounding toward -inf.
            avg_d = acc_q[ACC_W-1:AVG_LOG2];
            av_d  = 1'b1;
            acc_d = '0;
            grp_d = '0;
        end
    end

    // Averager flops.
    always_ff @(posedge clk5MHz) begin
        if (reset) begin
            acc_q <= '0;
            grp_q <= '0;
            avg_q <= '0;
            av_q  <= 1'b0;
        end else begin
            acc_q <= acc_d;
            grp_q <= grp_d;
            avg_q <= avg_d;
            av_q  <= av_d;
        end
    end

    assign abs_theta   = abs_q;
    assign period      = per_q;
    assign lead        = lead_q;
    assign theta_valid = tv_q;
    assign theta_avg   = avg_q;
    assign avg_valid   = av_q;
    assign stall       = stall_q;

endmodule

// File: tb/tb_phase_meter_avg.sv
// Bench for phase_meter_avg: table of steady-state phase configurations, hand-written
// reset/stall/edge sequences and randomized waveforms against a cycle-level model.
`timescale 1ns / 1ps
module tb_phase_meter_avg;

    logic       clk5MHz = 1'b0;
    logic       reset   = 1'b1;
    logic       I       = 1'b0;
    logic       V       = 1'b0;
    logic       cycle   = 1'b0;
    logic [7:0] abs_theta, period;
    logic       lead, theta_valid, avg_valid, stall;
    logic [8:0] theta_avg;

    phase_meter_avg #(
        .CNT_W      (8),
        .AVG_LOG2   (2),
        .SYNC_STAGES(2)
    ) dut (
        .clk5MHz    (clk5MHz),
        .reset      (reset),
        .I          (I),
        .V          (V),
        .cycle      (cycle),
        .abs_theta  (abs_theta),
        .period     (period),
        .lead       (lead),
        .theta_valid(theta_valid),
        .theta_avg  (theta_avg),
        .avg_valid  (avg_valid),
        .stall      (stall)
    );

    always #100 clk5MHz = ~clk5MHz;

    typedef struct {
        int abs_v;
        int per_v;
        int lead_v;
    } theta_t;

    typedef struct {
        int per;
        int oi;
        int ov;
        int e_abs;
        int e_lead;
        int e_avg;
    } vec_t;

    int total = 0;
    int bad   = 0;

    // Reference model state, in terms of pin samples and whole cycles.
    theta_t exp_q[$];
    int     avg_q[$];
    int     grp[$];
    int     m_armed, m_ph, m_since, m_dir, m_pi, m_pv, m_pc;

    // What the outputs should currently show.
    int cur_abs, cur_per, cur_lead, cur_avg;
    int n_theta = 0;
    int n_avg   = 0;
    logic tv_prev = 1'b0;

    task automatic chk(input string name, input int got, input int want);
        total++;
        if (got != want) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, got, want, $time);
        end
    endtask

    function automatic void model_reset();
        m_armed = 0;
        m_ph    = 0;
        m_since = 0;
        m_dir   = 0;
        m_pi    = 0;
        m_pv    = 0;
        m_pc    = 0;
        grp.delete();
        exp_q.delete();
        avg_q.delete();
        cur_abs  = 0;
        cur_per  = 0;
        cur_lead = 0;
        cur_avg  = 0;
    endfunction

    // One pin sample. A cycle spans the samples after one cycle rise up to and
    // including the next; lead is the direction set by edges before the closing sample.
    function automatic void model_step(input int i, input int v, input int c);
        int     rise;
        int     sum;
        int     q;
        theta_t t;
        rise = (c == 1 && m_pc == 0);
        m_since++;
        if (i != v) m_ph++;
        if (m_armed == 1 && m_since == 256) begin
            m_armed = 0;
            grp.delete();
        end else if (rise == 1) begin
            if (m_armed == 1) begin
                t.abs_v  = (m_ph > 255) ? 255 : m_ph;
                t.per_v  = (m_since > 255) ? 255 : m_since;
                t.lead_v = m_dir;
                exp_q.push_back(t);
                grp.push_back(m_dir == 1 ? -t.abs_v : t.abs_v);
                if (grp.size() == 4) begin
                    sum = grp[0] + grp[1] + grp[2] + grp[3];
                    q = sum / 4;
                    if (sum < 0 && (sum % 4) != 0) q = q - 1;
                    avg_q.push_back(q);
                    grp.delete();
                end
            end else begin
                m_armed = 1;
            end
        end
        if (rise == 1) begin
            m_ph    = 0;
            m_since = 0;
        end
        if (i == 1 && m_pi == 0 && v == 0) m_dir = 1;
        else if (v == 1 && m_pv == 0 && i == 0) m_dir = 0;
        m_pi = i;
        m_pv = v;
        m_pc = c;
    endfunction

    task automatic check_outputs();
        theta_t e;
        if (theta_valid === 1'b1) begin
            n_theta++;
            chk("theta_expected", int'(exp_q.size() > 0), 1);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                cur_abs  = e.abs_v;
                cur_per  = e.per_v;
                cur_lead = e.lead_v;
            end
            chk("stall_at_theta", int'(stall), 0);
        end
        chk("abs_theta", int'(abs_theta), cur_abs);
        chk("period", int'(period), cur_per);
        chk("lead", int'(lead), cur_lead);
        if (avg_valid === 1'b1) begin
            n_avg++;
            chk("avg_after_theta", int'(tv_prev), 1);
            chk("avg_expected", int'(avg_q.size() > 0), 1);
            if (avg_q.size() > 0) cur_avg = avg_q.pop_front();
        end
        chk("theta_avg", int'($signed(theta_avg)), cur_avg);
        tv_prev = theta_valid;
    endtask

    task automatic tick(input logic i, input logic v, input logic c);
        @(negedge clk5MHz);
        check_outputs();
        I     = i;
        V     = v;
        cycle = c;
        model_step(int'(i), int'(v), int'(c));
    endtask

    task automatic do_reset();
        @(negedge clk5MHz);
        reset = 1'b1;
        I     = 1'b0;
        V     = 1'b0;
        cycle = 1'b0;
        @(negedge clk5MHz);
        reset = 1'b0;
        chk("pending_theta_at_reset", exp_q.size(), 0);
        chk("pending_avg_at_reset", avg_q.size(), 0);
        model_reset();
        chk("rst_abs", int'(abs_theta), 0);
        chk("rst_period", int'(period), 0);
        chk("rst_lead", int'(lead), 0);
        chk("rst_theta_valid", int'(theta_valid), 0);
        chk("rst_theta_avg", int'(theta_avg), 0);
        chk("rst_avg_valid", int'(avg_valid), 0);
        chk("rst_stall", int'(stall), 0);
        tv_prev = 1'b0;
    endtask

    // Cycle high for the first half; I and V are 50% squares rising at oi / ov.
    task automatic wave_tick(input int per, input int oi, input int ov, input int t);
        int h;
        h = per / 2;
        tick(((t - oi + per) % per) < h, ((t - ov + per) % per) < h, t < h);
    endtask

    task automatic run_cycles(input int per, input int oi, input int ov, input int n);
        for (int k = 0; k < n; k++) begin
            for (int t = 0; t < per; t++) wave_tick(per, oi, ov, t);
        end
    endtask

    task automatic run_noise(input int per);
        for (int t = 0; t < per; t++) begin
            tick(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), t < per / 2);
        end
    endtask

    vec_t tbl[8];
    int   t0, a0;

    initial begin
        //         per  oi   ov  abs lead  avg
        tbl[0] = '{156, 49,  10,  78, 0,   78};  // V leads 90 deg
        tbl[1] = '{156, 10,  30,  40, 1,  -40};  // I leads ~45 deg
        tbl[2] = '{156, 10,  10,   0, 0,    0};  // in phase
        tbl[3] = '{156, 88,  10, 156, 1, -156};  // anti-phase
        tbl[4] = '{100, 10,  35,  50, 1,  -50};
        tbl[5] = '{200, 60,  10, 100, 0,  100};
        tbl[6] = '{240, 10, 130, 240, 0,  240};
        tbl[7] = '{ 60, 10,  20,  20, 1,  -20};

        do_reset();

        // Steady-state table: arm + 5 closed cycles, one full average group.
        for (int r = 0; r < 8; r++) begin
            do_reset();
            t0 = n_theta;
            a0 = n_avg;
            run_cycles(tbl[r].per, tbl[r].oi, tbl[r].ov, 6);
            chk("row_theta_count", n_theta - t0, 5);
            chk("row_avg_count", n_avg - a0, 1);
            chk("row_abs", int'(abs_theta), tbl[r].e_abs);
            chk("row_period", int'(period), tbl[r].per);
            chk("row_lead", int'(lead), tbl[r].e_lead);
            chk("row_avg", int'($signed(theta_avg)), tbl[r].e_avg);
        end

        // Simultaneous I/V rises leave the earlier I-lead direction in place.
        do_reset();
        run_cycles(156, 10, 30, 3);
        chk("pre_inphase_lead", int'(lead), 1);
        run_cycles(156, 10, 10, 3);
        chk("inphase_abs", int'(abs_theta), 0);
        chk("inphase_lead_kept", int'(lead), 1);

        // Reset mid-cycle after two valid cycles discards the partial average.
        do_reset();
        t0 = n_theta;
        a0 = n_avg;
        run_cycles(156, 49, 10, 2);
        for (int t = 0; t < 78; t++) wave_tick(156, 49, 10, t);
        chk("rst_seq_theta_before", n_theta - t0, 2);
        do_reset();
        t0 = n_theta;
        a0 = n_avg;
        run_cycles(156, 49, 10, 4);
        chk("rst_seq_theta_3", n_theta - t0, 3);
        chk("rst_seq_no_avg_yet", n_avg - a0, 0);
        run_cycles(156, 49, 10, 1);
        chk("rst_seq_theta_4", n_theta - t0, 4);
        chk("rst_seq_avg", n_avg - a0, 1);
        chk("rst_seq_avg_val", int'($signed(theta_avg)), 78);

        // Stall: one 16 kHz cycle saturates the period counter.
        do_reset();
        run_cycles(156, 49, 10, 2);
        t0 = n_theta;
        run_cycles(312, 98, 20, 1);
        chk("stall_theta_count", n_theta - t0, 1);
        chk("stall_set", int'(stall), 1);
        run_cycles(156, 49, 10, 1);
        chk("stall_rearm_no_theta", n_theta - t0, 1);
        chk("stall_held", int'(stall), 1);
        run_cycles(156, 49, 10, 1);
        chk("stall_recover_theta", n_theta - t0, 2);
        chk("stall_cleared", int'(stall), 0);
        chk("stall_recover_abs", int'(abs_theta), 78);

        // Randomized waveforms against the model.
        do_reset();
        for (int k = 0; k < 40; k++) begin
            int kind, per;
            kind = $urandom_range(0, 9);
            if (kind == 0) begin
                run_noise($urandom_range(40, 200));
            end else if (kind == 1) begin
                per = $urandom_range(270, 320);
                run_cycles(per, $urandom_range(0, per - 1), $urandom_range(0, per - 1), 1);
            end else begin
                per = $urandom_range(40, 220);
                run_cycles(per, $urandom_range(0, per - 1), $urandom_range(0, per - 1),
                           $urandom_range(1, 3));
            end
        end
        run_cycles(100, 10, 40, 2);
        for (int t = 0; t < 8; t++) tick(1'b0, 1'b0, 1'b0);
        chk("pending_theta_end", exp_q.size(), 0);
        chk("pending_avg_end", avg_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
